// File: rtl/fetch_pc_sequencer.sv
// Program-counter and fetch sequencer: holds the PC, runs the imem req/ack handshake,
// chooses sequential/branch/jump next-PC on each acknowledged fetch and counts completed fetches.
module fetch_pc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
  parameter int unsigned      STEP     = 32'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  output logic [WIDTH-1:0] pc,
  output logic             next_sel,
  output logic             fetch_done,
  output logic [WIDTH-1:0] fetch_addr,
  output logic [15:0]      fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             next_sel_q, next_sel_d;
  logic             fetch_done_q, fetch_done_d;
  logic [WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [15:0]      fetch_count_q, fetch_count_d;

  logic [WIDTH-1:0] seq_pc_s;
  logic [WIDTH-1:0] branch_pc_s;
  logic             sel_s;
  logic [WIDTH-1:0] next_pc_s;

  // Next-PC candidates; the 2:1 select picks branch over sequential, jump overrides both.
  always_comb begin
    seq_pc_s    = pc_q + WIDTH'(STEP);
    branch_pc_s = seq_pc_s + branch_offset;
    sel_s       = branch_taken & ~jump;
    if (jump) begin
      next_pc_s = jump_target;
    end else if (sel_s) begin
      next_pc_s = branch_pc_s;
    end else begin
      next_pc_s = seq_pc_s;
    end
  end

  // Handshake state machine and fetch bookkeeping.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    next_sel_d    = next_sel_q;
    fetch_done_d  = 1'b0;
    fetch_addr_d  = fetch_addr_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = stall ? ST_HOLD : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          pc_d          = next_pc_s;
          fetch_addr_d  = pc_q;
          fetch_done_d  = 1'b1;
          fetch_count_d = fetch_count_q + 16'd1;
          next_sel_d    = sel_s;
          if (stall) begin
            state_d = ST_HOLD;
          end else if (!enable) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end else if (stall) begin
          // Outstanding fetch is abandoned; it is reissued at the same pc later.
          state_d = ST_HOLD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          state_d = enable ? ST_REQ : ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      next_sel_q    <= 1'b0;
      fetch_done_q  <= 1'b0;
      fetch_addr_q  <= {WIDTH{1'b0}};
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      next_sel_q    <= next_sel_d;
      fetch_done_q  <= fetch_done_d;
      fetch_addr_q  <= fetch_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign next_sel    = next_sel_q;
  assign fetch_done  = fetch_done_q;
  assign fetch_addr  = fetch_addr_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed vector table, a wrap/reset-in-REQ sequence on a
// second instance with RESET_PC near the top of the address space, and random stimulus vs a model.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, enable, stall, branch_taken, jump, imem_ack;
  logic [31:0] branch_offset, jump_target;
  logic        imem_req, next_sel, fetch_done;
  logic [31:0] imem_addr, pc, fetch_addr;
  logic [15:0] fetch_count;

  logic        rst2_n, en2, ack2;
  logic        req2, sel2, done2;
  logic [31:0] addr2, pc2, faddr2;
  logic [15:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000), .STEP(32'd4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .pc(pc), .next_sel(next_sel), .fetch_done(fetch_done),
    .fetch_addr(fetch_addr), .fetch_count(fetch_count)
  );

  fetch_pc_sequencer #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .STEP(32'd4)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .enable(en2), .stall(1'b0),
    .branch_taken(1'b0), .branch_offset(32'h0),
    .jump(1'b0), .jump_target(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .pc(pc2), .next_sel(sel2), .fetch_done(done2),
    .fetch_addr(faddr2), .fetch_count(cnt2)
  );

  // Reference model: fetch phase plus architectural values, advanced once per clock edge.
  localparam int P_IDLE = 0, P_FETCH = 1, P_PARK = 2;
  int          m_phase = P_IDLE;
  logic [31:0] m_pc = 32'h0, m_faddr = 32'h0;
  logic        m_sel = 1'b0, m_done = 1'b0;
  int          m_fetches = 0;

  task automatic model_edge();
    if (!rst_n) begin
      m_phase = P_IDLE; m_pc = 32'h0; m_sel = 1'b0; m_done = 1'b0;
      m_faddr = 32'h0; m_fetches = 0;
    end else begin
      m_done = 1'b0;
      if (m_phase == P_IDLE) begin
        if (enable) m_phase = stall ? P_PARK : P_FETCH;
      end else if (m_phase == P_FETCH) begin
        if (imem_ack) begin
          m_faddr = m_pc;
          if (jump) m_pc = jump_target;
          else if (branch_taken) m_pc = m_pc + 32'd4 + branch_offset;
          else m_pc = m_pc + 32'd4;
          m_sel = branch_taken && !jump;
          m_done = 1'b1;
          m_fetches++;
          m_phase = stall ? P_PARK : (enable ? P_FETCH : P_IDLE);
        end else if (stall) begin
          m_phase = P_PARK;
        end
      end else begin
        if (!stall) m_phase = enable ? P_FETCH : P_IDLE;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        rst_n, en, stall, bt;
    logic [31:0] bo;
    logic        jump;
    logic [31:0] jt;
    logic        ack;
    logic [31:0] e_pc;
    logic        e_req, e_sel, e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h000, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h004, 1'b1, 1'b0, 1'b1, 16'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h008, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h00C, 1'b1, 1'b0, 1'b1, 16'd3};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h010, 1'b1, 1'b0, 1'b1, 16'd4};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0, 1'b1, 32'h004, 1'b1, 1'b1, 1'b1, 16'd5};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 16'd6};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 16'd6};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 16'd6};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 16'd6};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 16'd6};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 16'd7};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 16'd8};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 16'd8};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b0, 1'b0, 1'b0, 16'd8};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 1'b0, 1'b0, 16'd8};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h000, 1'b0, 1'b0, 1'b0, 16'd0};

    rst2_n = 1'b0; en2 = 1'b0; ack2 = 1'b0;

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      rst_n = vecs[i].rst_n; enable = vecs[i].en; stall = vecs[i].stall;
      branch_taken = vecs[i].bt; branch_offset = vecs[i].bo;
      jump = vecs[i].jump; jump_target = vecs[i].jt; imem_ack = vecs[i].ack;
      step();
      check($sformatf("tbl%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].e_pc);
      check($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      check($sformatf("tbl%0d_sel", i), {31'd0, next_sel}, {31'd0, vecs[i].e_sel});
      check($sformatf("tbl%0d_done", i), {31'd0, fetch_done}, {31'd0, vecs[i].e_done});
      check($sformatf("tbl%0d_cnt", i), {16'd0, fetch_count}, {16'd0, vecs[i].e_cnt});
    end

    // Randomized stimulus against the model.
    for (int c = 0; c < 1500; c++) begin
      rst_n         = ($urandom_range(0, 63) != 0);
      enable        = ($urandom_range(0, 7) != 0);
      stall         = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 2) == 0);
      branch_offset = $urandom;
      jump          = ($urandom_range(0, 7) == 0);
      jump_target   = $urandom;
      imem_ack      = $urandom_range(0, 1) == 1;
      step();
      check("rnd_pc", pc, m_pc);
      check("rnd_addr", imem_addr, m_pc);
      check("rnd_req", {31'd0, imem_req}, {31'd0, (m_phase == P_FETCH)});
      check("rnd_sel", {31'd0, next_sel}, {31'd0, m_sel});
      check("rnd_done", {31'd0, fetch_done}, {31'd0, m_done});
      check("rnd_faddr", fetch_addr, m_faddr);
      check("rnd_cnt", {16'd0, fetch_count}, 32'(m_fetches % 65536));
    end

    // PC wrap from 0xFFFFFFFC and reset taken while a request is pending.
    rst2_n = 1'b0; en2 = 1'b1; ack2 = 1'b1;
    step();
    check("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
    check("wrap_rst_req", {31'd0, req2}, 32'd0);
    rst2_n = 1'b1; ack2 = 1'b0;
    step();
    check("wrap_req", {31'd0, req2}, 32'd1);
    check("wrap_addr", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1;
    step();
    check("wrap_pc", pc2, 32'h0000_0000);
    check("wrap_faddr", faddr2, 32'hFFFF_FFFC);
    check("wrap_done", {31'd0, done2}, 32'd1);
    check("wrap_cnt", {16'd0, cnt2}, 32'd1);
    ack2 = 1'b0;
    step();
    check("wrap_req_wait", {31'd0, req2}, 32'd1);
    check("wrap_done_clr", {31'd0, done2}, 32'd0);
    rst2_n = 1'b0;
    step();
    check("rstreq_req", {31'd0, req2}, 32'd0);
    check("rstreq_pc", pc2, 32'hFFFF_FFFC);
    check("rstreq_cnt", {16'd0, cnt2}, 32'd0);
    rst2_n = 1'b1; en2 = 1'b0;
    step();
    check("rstreq_idle", {31'd0, req2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
